// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester burst arbiter: FSM encoding and
// the default data path width.
package mux2_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

endpackage

// File: rtl/mux2_data.sv
// Combinational 2:1 select of one {last, data} word; sel = 1 picks data_1.
module mux2_data #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] data_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic             sel,
    output logic [WIDTH-1:0] data
);

    assign data = sel ? data_1 : data_0;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester burst arbiter with a round-robin priority pointer. A grant is
// held for a whole burst and handed over at burst end without a bubble.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_0,
    input  logic                  valid_1,
    input  logic [DATA_WIDTH-1:0] d_0,
    input  logic [DATA_WIDTH-1:0] d_1,
    input  logic                  last_0,
    input  logic                  last_1,
    output logic                  ready_0,
    output logic                  ready_1,
    output logic [DATA_WIDTH-1:0] mux_out,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  sel,
    output state_t                state,
    output logic                  prio
);

    // Handshake: a beat moves when valid and ready are both high in the same
    // cycle; ready never depends on valid, and the non-granted ready stays 0.

    state_t state_q, state_next;
    logic   prio_q, prio_next;

    assign sel   = (state_q == GRANT1);
    assign state = state_q;
    assign prio  = prio_q;

    mux2_data #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_data (
        .data_0({last_0, d_0}),
        .data_1({last_1, d_1}),
        .sel   (sel),
        .data  ({out_last, mux_out})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            prio_q  <= prio_next;
        end
    end

    always_comb begin
        state_next = state_q;
        prio_next  = prio_q;
        out_valid  = 1'b0;
        ready_0    = 1'b0;
        ready_1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_0 && valid_1) begin
                    state_next = prio_q ? GRANT1 : GRANT0;
                end else if (valid_0) begin
                    state_next = GRANT0;
                end else if (valid_1) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                out_valid = valid_0;
                ready_0   = out_ready;
                // Burst end hands the grant straight to the other side if it waits.
                if (valid_0 && out_ready && out_last) begin
                    prio_next  = 1'b1;
                    state_next = valid_1 ? GRANT1 : (valid_0 ? GRANT0 : IDLE);
                end
            end
            GRANT1: begin
                out_valid = valid_1;
                ready_1   = out_ready;
                if (valid_1 && out_ready && out_last) begin
                    prio_next  = 1'b0;
                    state_next = valid_0 ? GRANT0 : (valid_1 ? GRANT1 : IDLE);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each data path through the 2:1 mux.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid_0 / valid_1  input  1 each  requester n has a beat offered.
REQ-005 d_0 / d_1  input  DATA_WIDTH each  requester n beat data.
REQ-006 last_0 / last_1  input  1 each  current beat is last of requester n burst.
REQ-007 ready_0 / ready_1  output  1 each  beat from requester n accepted this cycle when high with valid_n.
REQ-008 mux_out  output  DATA_WIDTH  selected data.
REQ-009 out_valid  output  1  mux_out carries a valid beat.
REQ-010 out_last  output  1  selected last flag.
REQ-011 out_ready  input  1  downstream accepts beat when high with out_valid.
REQ-012 sel  output  1  current mux select (0 = requester 0, 1 = requester 1).

Function
REQ-013 FSM states SHALL be IDLE, GRANT0, GRANT1; sel SHALL be 1 only in GRANT1.
REQ-014 mux_out and out_last SHALL be combinational: sel ? d_1 : d_0, and sel ? last_1 : last_0 respectively.
REQ-015 out_valid SHALL be valid_0 in GRANT0, valid_1 in GRANT1, 0 in IDLE.
REQ-016 ready_n SHALL be out_ready in GRANTn, 0 otherwise; the non-granted ready SHALL be 0.
REQ-017 Beat accepted = out_valid && out_ready; burst end = accepted beat with out_last = 1.
REQ-018 IDLE: only valid_0 -> GRANT0 next cycle; only valid_1 -> GRANT1; both -> requester indicated by priority pointer prio; neither -> stay IDLE.
REQ-019 Arbitration latency SHALL be exactly one cycle: no beat is accepted in the IDLE cycle.
REQ-020 GRANTn SHALL be held, regardless of the other requester, until burst end of requester n.
REQ-021 On burst end in GRANTn: prio SHALL become the other requester; next state SHALL be GRANT(other) if valid_(other) is high that cycle, else GRANTn if valid_n is high, else IDLE (no bubble between back-to-back bursts).
REQ-022 valid_n dropping mid-burst in GRANTn SHALL leave the grant held; out_valid follows valid_n low.
REQ-023 out_ready low SHALL stall: no state change, prio unchanged, mux_out reflects the granted input.
REQ-024 Single-beat bursts (last on first beat) SHALL be legal and end the burst that cycle.
REQ-025 Over any window with both valids continuously high, grants SHALL strictly alternate burst by burst.

Reset
REQ-026 While rst_n low: state IDLE, prio = 0, sel = 0, out_valid = 0, ready_0 = ready_1 = 0.
REQ-027 Assertion mid-burst SHALL abort the burst immediately (asynchronous); no beat is accepted in the cycle rst_n is low.
REQ-028 First arbitration SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 Shared package mux2_arb_pkg SHALL hold the state enumeration and the default DATA_WIDTH constant.
REQ-030 The data/last selection SHALL be a sub-module mux2_data (DATA_WIDTH+1 bits, combinational 2:1), instantiated once; FSM and prio live in mux2_arbiter.

Verification
REQ-031 Reset then valid_0 = 1, d_0 = 0xA5, last_0 = 1, out_ready = 1 -> cycle 1 IDLE, cycle 2 sel = 0, mux_out = 0xA5, ready_0 = 1, then IDLE.
REQ-032 Both valid from reset, each sends 3-beat bursts continuously, out_ready = 1 -> grant sequence 0,1,0,1 with sel toggling exactly at burst ends and no idle cycles between bursts.
REQ-033 GRANT1 mid-burst, valid_0 rises -> ready_0 stays 0 until last_1 beat accepted, then GRANT0 the next cycle.
REQ-034 out_ready held low 5 cycles during GRANT0 with last_0 = 1 -> state, sel, prio unchanged; beat accepted on the first cycle out_ready = 1.
REQ-035 rst_n pulsed low during second beat of a GRANT1 burst -> out_valid, ready_1, sel all 0 immediately; after release, valid_0 and valid_1 both high -> GRANT0 (prio = 0).
